// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display blocks.
// All patterns are active-low: bit7 = dp (off), bits 6..0 = g,f,e,d,c,b,a.
package seg7_pkg;

  localparam logic [7:0] SEG_OFF   = 8'hFF;
  localparam logic [3:0] SEL_OFF   = 4'hF;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [7:0] SEG_TABLE [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex digit to active-low 7-segment pattern (g..a, no dp).
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_TABLE[code][6:0];
  end

endmodule

// File: rtl/seg7_scan_4dig.sv
// Four-digit multiplexed common-anode display driver with per-slot blanking
// guard, leading-zero suppression and a once-per-frame input snapshot.
module seg7_scan_4dig
  import seg7_pkg::*;
#(
  parameter int DIV_BITS = 16,
  parameter int GUARD    = 64,
  parameter int BLANK_LZ = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] dig0,
  input  logic [3:0] dig1,
  input  logic [3:0] dig2,
  input  logic [3:0] dig3,
  input  logic [3:0] dp_in,
  output logic [3:0] sel,
  output logic [7:0] seg,
  output logic       frame_start
);

  localparam logic [DIV_BITS-1:0] GUARD_P = DIV_BITS'(GUARD);

  logic [DIV_BITS-1:0] p_q, p_d;
  logic [1:0]          idx_q, idx_d;
  logic [3:0][3:0]     snap_q, snap_d;
  logic [3:0]          dp_snap_q, dp_snap_d;
  logic [3:0]          sel_q, sel_d;
  logic [7:0]          seg_q, seg_d;
  logic                frame_start_q, frame_start_d;

  logic       p_max;
  logic       snap_en;
  logic       in_guard;
  logic [3:0] blank_vec;
  logic [6:0] dec_seg;

  // A zero guard would make the compare constant-false, so drop it entirely.
  generate
    if (GUARD == 0) begin : g_no_guard
      assign in_guard = 1'b0;
    end else begin : g_guard
      assign in_guard = (p_q < GUARD_P);
    end
  endgenerate

  seg7_decode u_decode (
    .code  (snap_q[idx_q]),
    .seg_n (dec_seg)
  );

  always_comb begin
    p_max   = &p_q;
    snap_en = p_max && (idx_q == 2'd3);

    p_d           = p_q + 1'b1;
    idx_d         = p_max ? idx_q + 2'd1 : idx_q;
    snap_d        = snap_en ? {dig3, dig2, dig1, dig0} : snap_q;
    dp_snap_d     = snap_en ? dp_in : dp_snap_q;
    frame_start_d = snap_en;

    blank_vec[0] = 1'b0;
    blank_vec[3] = (BLANK_LZ != 0) && (snap_q[3] == 4'd0);
    blank_vec[2] = blank_vec[3] && (snap_q[2] == 4'd0);
    blank_vec[1] = blank_vec[2] && (snap_q[1] == 4'd0);

    if (in_guard) begin
      sel_d = SEL_OFF;
      seg_d = SEG_OFF;
    end else begin
      sel_d = ~(4'b0001 << idx_q);
      seg_d = {~dp_snap_q[idx_q], blank_vec[idx_q] ? SEG_BLANK : dec_seg};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q           <= '0;
      idx_q         <= 2'd0;
      snap_q        <= '0;
      dp_snap_q     <= 4'd0;
      sel_q         <= SEL_OFF;
      seg_q         <= SEG_OFF;
      frame_start_q <= 1'b0;
    end else begin
      p_q           <= p_d;
      idx_q         <= idx_d;
      snap_q        <= snap_d;
      dp_snap_q     <= dp_snap_d;
      sel_q         <= sel_d;
      seg_q         <= seg_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign sel         = sel_q;
  assign seg         = seg_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_4dig.sv
// Directed bench for seg7_scan_4dig: a guarded blanking instance, an
// unguarded non-blanking instance, and a wider prescaler for frame period.
module tb_seg7_scan_4dig;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] dig0, dig1, dig2, dig3, dp_in;

  logic [3:0] sel_a, sel_b, sel_c;
  logic [7:0] seg_a, seg_b, seg_c;
  logic       fs_a, fs_b, fs_c;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seg7_scan_4dig #(.DIV_BITS(4), .GUARD(2), .BLANK_LZ(1)) u_dut_a (
    .clk(clk), .rst(rst), .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
    .dp_in(dp_in), .sel(sel_a), .seg(seg_a), .frame_start(fs_a)
  );

  seg7_scan_4dig #(.DIV_BITS(4), .GUARD(0), .BLANK_LZ(0)) u_dut_b (
    .clk(clk), .rst(rst), .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
    .dp_in(dp_in), .sel(sel_b), .seg(seg_b), .frame_start(fs_b)
  );

  seg7_scan_4dig #(.DIV_BITS(10), .GUARD(64), .BLANK_LZ(1)) u_dut_c (
    .clk(clk), .rst(rst), .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
    .dp_in(dp_in), .sel(sel_c), .seg(seg_c), .frame_start(fs_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [19:0] v);
    {dp_in, dig3, dig2, dig1, dig0} = v;
  endtask

  // Starts at the negedge where state is p=0, idx=0 and walks the 64
  // following cycles; exp_* hold the slot patterns, slot 0 in the low byte.
  task automatic check_frame(input string name, input logic [31:0] exp_a,
                             input logic [31:0] exp_b, input logic chg,
                             input logic [19:0] nxt);
    int s;
    int p;
    logic [3:0] esel;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      s = (k - 1) / 16;
      p = (k - 1) % 16;
      esel = ~(4'b0001 << s);
      if (p < 2) begin
        chk($sformatf("%s k%0d sel_a guard", name, k), sel_a, 4'hF);
        chk($sformatf("%s k%0d seg_a guard", name, k), seg_a, 8'hFF);
      end else begin
        chk($sformatf("%s k%0d sel_a", name, k), sel_a, esel);
        chk($sformatf("%s k%0d seg_a", name, k), seg_a, exp_a[8*s +: 8]);
      end
      chk($sformatf("%s k%0d sel_b", name, k), sel_b, esel);
      chk($sformatf("%s k%0d seg_b", name, k), seg_b, exp_b[8*s +: 8]);
      chk($sformatf("%s k%0d fs_a", name, k), fs_a, (k == 64));
      chk($sformatf("%s k%0d fs_b", name, k), fs_b, (k == 64));
      if (chg && k == 24) set_in(nxt);
    end
  endtask

  initial begin
    int cnt;
    set_in(20'h0_0000);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst sel_a", sel_a, 4'hF);
      chk("rst seg_a", seg_a, 8'hFF);
      chk("rst fs_a", fs_a, 1'b0);
      chk("rst sel_b", sel_b, 4'hF);
      chk("rst seg_b", seg_b, 8'hFF);
      chk("rst sel_c", sel_c, 4'hF);
    end
    rst = 1'b0;

    // Zero snapshot, then 1234 loaded mid-frame (must not show until next frame).
    check_frame("f_zero", 32'hFFFFFFC0, 32'hC0C0C0C0, 1'b1, 20'h0_1234);
    // 1234; switch to 5678 during slot 1, slots 2/3 must keep old digits.
    check_frame("f_1234", 32'hF9A4B099, 32'hF9A4B099, 1'b1, 20'h0_5678);
    check_frame("f_5678", 32'h9282F880, 32'h9282F880, 1'b1, 20'h4_0040);
    // 0040 with dp on digit 2: blanked with dp lit vs. unblanked.
    check_frame("f_0040", 32'hFF7F99C0, 32'hC04099C0, 1'b1, 20'h9_FE0A);
    // Hex letters, interior zero kept, dp on digits 0 and 3.
    check_frame("f_FE0A", 32'h0E86C008, 32'h0E86C008, 1'b0, 20'h0_0000);

    repeat (40) @(negedge clk);
    chk("pre_rst sel_a", sel_a, 4'hB);
    chk("pre_rst seg_a", seg_a, 8'h86);
    chk("pre_rst seg_b", seg_b, 8'h86);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst sel_a", sel_a, 4'hF);
    chk("mid_rst seg_a", seg_a, 8'hFF);
    chk("mid_rst sel_b", sel_b, 4'hF);
    chk("mid_rst seg_b", seg_b, 8'hFF);
    chk("mid_rst fs_a", fs_a, 1'b0);
    check_frame("f_after_rst", 32'hFFFFFFC0, 32'hC0C0C0C0, 1'b0, 20'h0_0000);

    cnt = 0;
    while (!fs_c && cnt < 10000) begin
      @(negedge clk);
      cnt++;
    end
    chk("big first frame_start seen", fs_c, 1'b1);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!fs_c && cnt < 10000);
    chk("big frame period", cnt, 32'd4096);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
